div_sdm_mash: RTL and testbench



---
 rtl/div_sdm_pkg.sv | 13 +
 rtl/sdm_acc_stage.sv | 32 +++
 rtl/div_sdm_mash.sv | 90 +++++++++
 tb/tb_div_sdm_mash.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_sdm_pkg.sv
// div_sdm_pkg: shared constants for the MASH 1-1-1 fractional-N modulator.
// Defines the default accumulator and divide-word widths, the dither LFSR seed,
// the feedback tap mask for x^15+x^14+1, and the modulator output range.
package div_sdm_pkg;
    localparam int          ACC_W     = 16;
    localparam int          N_W       = 6;
    localparam int          LFSR_W    = 15;
    localparam logic [14:0] LFSR_SEED = 15'h7FFF;
    // Feedback is the XOR of the x^15 and x^14 terms, which are bits 14 and 13.
    localparam logic [14:0] LFSR_TAPS = 15'h6000;
    localparam int          Y_MIN     = -3;
    localparam int          Y_MAX     = 4;
endpackage

// File: rtl/sdm_acc_stage.sv
// sdm_acc_stage: one first-order accumulator stage with carry out.
// Ports:
//   clk, rstn - clock and asynchronous active-low reset
//   clr       - synchronous clear of the accumulator (bypass mode)
//   addend    - value added to the accumulator this cycle
//   cin       - extra 1-LSB input (dither on stage 1, zero elsewhere)
//   sum       - next accumulator value, combinational, feeds the next stage
//   carry     - overflow of this cycle's addition
module sdm_acc_stage
    import div_sdm_pkg::*;
#(
    parameter int W = ACC_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [W-1:0] addend,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         carry
);
    logic [W-1:0] acc;

    assign {carry, sum} = (W+1)'(acc) + (W+1)'(addend) + (W+1)'(cin);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            acc <= '0;
        else
            acc <= clr ? '0 : sum;
    end
endmodule

// File: rtl/div_sdm_mash.sv
// div_sdm_mash: third-order MASH 1-1-1 sigma-delta modulator for the fractional-N divider.
// Ports:
//   clk, rstn  - divider/reference-rate clock, asynchronous active-low reset
//   enable     - modulator enable; low selects bypass and clears all state
//   cfg_upd    - single-cycle pulse loading frac/div_n into the shadow regs while running
//   frac       - unsigned fractional word, value frac/2^ACC_W
//   div_n      - integer divide word
//   dither_en  - adds a 1-LSB pseudo-random dither into stage 1
//   div_ratio  - registered divide ratio, never negative
//   div_valid  - div_ratio carries modulator output rather than bypass
//   sdm_nc_out - stage-1 residue acc1[ACC_W-1:1] for the noise-cancellation DAC
module div_sdm_mash #(
    parameter int          ACC_W     = div_sdm_pkg::ACC_W,
    parameter int          N_W       = div_sdm_pkg::N_W,
    parameter logic [14:0] LFSR_SEED = div_sdm_pkg::LFSR_SEED
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             cfg_upd,
    input  logic [ACC_W-1:0] frac,
    input  logic [N_W-1:0]   div_n,
    input  logic             dither_en,
    output logic [N_W+1:0]   div_ratio,
    output logic             div_valid,
    output logic [ACC_W-2:0] sdm_nc_out
);
    import div_sdm_pkg::LFSR_TAPS;

    logic [ACC_W-1:0] frac_s, sum1, sum2, sum3;
    logic [N_W-1:0]   div_n_s;
    logic [14:0]      lfsr;
    logic             c1, c2, c3, c2_d, c3_d, c3_dd;
    logic [3:0]       y;
    logic [N_W+1:0]   ratio_sum;

    sdm_acc_stage #(.W(ACC_W)) u_s1 (
        .clk(clk), .rstn(rstn), .clr(!enable),
        .addend(frac_s), .cin(dither_en & lfsr[0]), .sum(sum1), .carry(c1)
    );
    sdm_acc_stage #(.W(ACC_W)) u_s2 (
        .clk(clk), .rstn(rstn), .clr(!enable),
        .addend(sum1), .cin(1'b0), .sum(sum2), .carry(c2)
    );
    sdm_acc_stage #(.W(ACC_W)) u_s3 (
        .clk(clk), .rstn(rstn), .clr(!enable),
        .addend(sum2), .cin(1'b0), .sum(sum3), .carry(c3)
    );

    // Modulo-16 arithmetic is exact here because y always lies in -3..+4.
    assign y = 4'(c1) + 4'(c2) + 4'(c3) + 4'(c3_dd) - 4'(c2_d) - {2'b00, c3_d, 1'b0};
    assign ratio_sum = {2'b00, div_n_s} + {{(N_W-2){y[3]}}, y};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frac_s     <= '0;
            div_n_s    <= '0;
            lfsr       <= LFSR_SEED;
            c2_d       <= 1'b0;
            c3_d       <= 1'b0;
            c3_dd      <= 1'b0;
            div_ratio  <= '0;
            div_valid  <= 1'b0;
            sdm_nc_out <= '0;
        end else begin
            if (!enable || cfg_upd) begin
                frac_s  <= frac;
                div_n_s <= div_n;
            end
            if (!enable) begin
                lfsr       <= LFSR_SEED;
                c2_d       <= 1'b0;
                c3_d       <= 1'b0;
                c3_dd      <= 1'b0;
                div_ratio  <= {2'b00, div_n};
                div_valid  <= 1'b0;
                sdm_nc_out <= '0;
            end else begin
                lfsr       <= {lfsr[13:0], ^(lfsr & LFSR_TAPS)};
                c2_d       <= c2;
                c3_d       <= c3;
                c3_dd      <= c3_d;
                // A negative sum clamps to zero instead of wrapping.
                div_ratio  <= ratio_sum[N_W+1] ? '0 : ratio_sum;
                div_valid  <= 1'b1;
                sdm_nc_out <= sum1[ACC_W-1:1];
            end
        end
    end
endmodule

// File: tb/tb_div_sdm_mash.sv
// tb_div_sdm_mash: directed self-checking bench for div_sdm_mash against a behavioural model.
module tb_div_sdm_mash;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_upd = 1'b0;
    logic [15:0] frac = '0;
    logic [5:0]  div_n = '0;
    logic        dither_en = 1'b0;
    logic [7:0]  div_ratio;
    logic        div_valid;
    logic [14:0] sdm_nc_out;

    int n_checks = 0;
    int n_fail = 0;

    int m_acc1, m_acc2, m_acc3, m_c2d, m_c3d, m_c3dd, m_frac_s, m_dn_s, m_clip;
    logic [14:0] m_lfsr;
    int exp_ratio, exp_valid, exp_nc;

    div_sdm_mash dut (
        .clk(clk), .rstn(rstn), .enable(enable), .cfg_upd(cfg_upd), .frac(frac),
        .div_n(div_n), .dither_en(dither_en), .div_ratio(div_ratio),
        .div_valid(div_valid), .sdm_nc_out(sdm_nc_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
        m_c2d = 0; m_c3d = 0; m_c3dd = 0;
        m_frac_s = 0; m_dn_s = 0; m_clip = 0;
        m_lfsr = 15'h7FFF;
        exp_ratio = 0; exp_valid = 0; exp_nc = 0;
    endtask

    // Drives one cycle of inputs, waits for the edge, and advances the model.
    task automatic cyc(input bit en, input bit upd, input int f, input int n, input bit dth);
        int s, c1, c2, c3, y, r, d;
        enable = en; cfg_upd = upd; frac = f[15:0]; div_n = n[5:0]; dither_en = dth;
        @(posedge clk);
        #1;
        if (!en) begin
            m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
            m_c2d = 0; m_c3d = 0; m_c3dd = 0;
            m_lfsr = 15'h7FFF;
            m_frac_s = f; m_dn_s = n;
            exp_ratio = n; exp_valid = 0; exp_nc = 0;
        end else begin
            d = dth ? int'(m_lfsr[0]) : 0;
            s = m_acc1 + m_frac_s + d; c1 = s / 65536; m_acc1 = s % 65536;
            s = m_acc2 + m_acc1;       c2 = s / 65536; m_acc2 = s % 65536;
            s = m_acc3 + m_acc2;       c3 = s / 65536; m_acc3 = s % 65536;
            y = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
            r = m_dn_s + y;
            if (r < 0) m_clip = m_clip - r;
            exp_ratio = (r < 0) ? 0 : r;
            exp_valid = 1;
            exp_nc = m_acc1 / 2;
            m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
            if (upd) begin m_frac_s = f; m_dn_s = n; end
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        n_checks++;
        if (div_ratio !== 8'd0 || div_valid !== 1'b0 || sdm_nc_out !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ratio=%0d valid=%0b nc=%0h, want 0 0 0", div_ratio, div_valid, sdm_nc_out);
        end
        @(negedge clk) rstn = 1'b1;
        model_reset();
        cyc(0, 0, 0, 20, 0);
        n_checks++;
        if (div_ratio !== 8'd20 || div_valid !== 1'b0 || sdm_nc_out !== 15'd0) begin
            n_fail++;
            $display("FAIL bypass_div20: got ratio=%0d valid=%0b nc=%0h, want 20 0 0", div_ratio, div_valid, sdm_nc_out);
        end
        n_checks++;
        if (dut.lfsr !== 15'h7FFF) begin
            n_fail++;
            $display("FAIL reset_lfsr: got %h, want 7fff", dut.lfsr);
        end
    endtask

    task automatic test_frac_zero();
        int bad = 0;
        cyc(0, 0, 0, 20, 0);
        for (int i = 0; i < 1000; i++) begin
            cyc(1, 0, 0, 20, 0);
            if (div_ratio !== 8'd20 || div_valid !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL frac_zero: %0d cycles off ratio=20/valid=1, want 0 (last ratio=%0d valid=%0b)", bad, div_ratio, div_valid);
        end
    endtask

    task automatic test_half();
        int sum = 0, mn = 255, mx = 0;
        cyc(0, 0, 'h8000, 20, 0);
        cyc(1, 0, 'h8000, 20, 0);
        n_checks++;
        if (div_ratio !== 8'd20 || div_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL half_cycle1: got ratio=%0d valid=%0b, want 20 1", div_ratio, div_valid);
        end
        sum += int'(div_ratio) - 20;
        cyc(1, 0, 'h8000, 20, 0);
        n_checks++;
        if (div_ratio !== 8'd22) begin
            n_fail++;
            $display("FAIL half_cycle2: got ratio=%0d, want 22", div_ratio);
        end
        sum += int'(div_ratio) - 20;
        for (int i = 2; i < 1024; i++) begin
            cyc(1, 0, 'h8000, 20, 0);
            sum += int'(div_ratio) - 20;
            if (int'(div_ratio) < mn) mn = int'(div_ratio);
            if (int'(div_ratio) > mx) mx = int'(div_ratio);
        end
        n_checks++;
        if (sum < 509 || sum > 515) begin
            n_fail++;
            $display("FAIL half_sum: got %0d, want 512+-3", sum);
        end
        n_checks++;
        if (mn < 17 || mx > 24) begin
            n_fail++;
            $display("FAIL half_range: got min=%0d max=%0d, want within 17..24", mn, mx);
        end
    endtask

    task automatic test_dither();
        int bad = 0, wrapped = 0;
        longint sum = 0, excess;
        cyc(0, 0, 1, 2, 1);
        for (int i = 0; i < 65536; i++) begin
            cyc(1, 0, 1, 2, 1);
            if (div_ratio !== 8'(exp_ratio) || sdm_nc_out !== 15'(exp_nc) || div_valid !== 1'b1) bad++;
            if (div_ratio[7]) wrapped++;
            sum += longint'(div_ratio);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dither_model: %0d cycles disagree with model, want 0", bad);
        end
        n_checks++;
        if (wrapped != 0) begin
            n_fail++;
            $display("FAIL dither_nowrap: %0d negative-wrapped samples, want 0", wrapped);
        end
        excess = sum - 2 * 65536 - longint'(m_clip);
        n_checks++;
        if (excess < -2 || excess > 4) begin
            n_fail++;
            $display("FAIL dither_mean: got excess %0d over 2*N after clip correction, want 1+-3", excess);
        end
    endtask

    task automatic test_cfg_upd();
        cyc(0, 0, 'h4000, 20, 0);
        for (int i = 0; i < 20; i++) begin
            if (i < 8)       cyc(1, 0, 'h4000, 20, 0);
            else if (i < 11) cyc(1, 0, 'hC000, 25, 0);
            else if (i == 11) cyc(1, 1, 'hC000, 25, 0);
            else             cyc(1, 0, 'hC000, 25, 0);
            n_checks++;
            if (div_ratio !== 8'(exp_ratio) || sdm_nc_out !== 15'(exp_nc) || div_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL cfg_upd_step%0d: got ratio=%0d nc=%0h valid=%0b, want %0d %0h 1", i, div_ratio, sdm_nc_out, div_valid, exp_ratio, exp_nc);
            end
        end
    endtask

    task automatic test_disable_reset();
        for (int i = 0; i < 5; i++) cyc(1, 0, 'h6000, 30, 1);
        cyc(0, 0, 'h6000, 33, 1);
        n_checks++;
        if (div_ratio !== 8'd33 || div_valid !== 1'b0 || sdm_nc_out !== 15'd0) begin
            n_fail++;
            $display("FAIL disable_bypass: got ratio=%0d valid=%0b nc=%0h, want 33 0 0", div_ratio, div_valid, sdm_nc_out);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 'h4000, 33, 1);
            n_checks++;
            if (div_ratio !== 8'(exp_ratio) || sdm_nc_out !== 15'(exp_nc)) begin
                n_fail++;
                $display("FAIL restart_step%0d: got ratio=%0d nc=%0h, want %0d %0h", i, div_ratio, sdm_nc_out, exp_ratio, exp_nc);
            end
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (div_ratio !== 8'd0 || div_valid !== 1'b0 || sdm_nc_out !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ratio=%0d valid=%0b nc=%0h, want 0 0 0", div_ratio, div_valid, sdm_nc_out);
        end
        #1 rstn = 1'b1;
        model_reset();
        n_checks++;
        if (dut.lfsr !== 15'h7FFF) begin
            n_fail++;
            $display("FAIL release_lfsr: got %h, want 7fff", dut.lfsr);
        end
        cyc(0, 0, 'h4000, 12, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 'h4000, 12, 1);
            n_checks++;
            if (div_ratio !== 8'(exp_ratio) || sdm_nc_out !== 15'(exp_nc)) begin
                n_fail++;
                $display("FAIL post_reset_step%0d: got ratio=%0d nc=%0h, want %0d %0h", i, div_ratio, sdm_nc_out, exp_ratio, exp_nc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frac_zero();
        test_half();
        test_dither();
        test_cfg_upd();
        test_disable_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
